// File: rtl/mdu_sequencer.sv
// ============================================================================
// Module   : mdu_sequencer
// Purpose  : E-stage multiply/divide controller. It owns HI/LO and runs a
//            fixed-latency mult/div sequence. Define MDU_MADD_EN to add the
//            madd/maddu/msub/msubu accumulate ops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
    localparam logic [3:0] c_OP_MFHI  = 4'd7;
    localparam logic [3:0] c_OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] c_OP_MADD  = 4'd9;
    localparam logic [3:0] c_OP_MADDU = 4'd10;
    localparam logic [3:0] c_OP_MSUB  = 4'd11;
    localparam logic [3:0] c_OP_MSUBU = 4'd12;
`endif

    localparam logic [3:0] c_MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_LD  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_pend;
    logic        r_pend_wr;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_signed;
    logic        w_divz;
    logic [31:0] w_ua;
    logic [31:0] w_ub;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [63:0] w_calc;
    logic        w_calc_wr;
    logic        w_is_run;
    logic        w_is_div;
    logic [3:0]  w_cnt_load;

    assign w_prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    assign w_prod_u = {32'd0, rs_data} * {32'd0, rt_data};

    // Signed divide runs on magnitudes so 0x80000000 / -1 never overflows.
    assign w_div_signed = (mdu_op == c_OP_DIV);
    assign w_divz       = (rt_data == 32'd0);
    assign w_ua  = (w_div_signed && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
    assign w_ub  = w_divz ? 32'd1 :
                   ((w_div_signed && rt_data[31]) ? (32'd0 - rt_data) : rt_data);
    assign w_uq  = w_ua / w_ub;
    assign w_ur  = w_ua % w_ub;
    assign w_quo = (w_div_signed && (rs_data[31] ^ rt_data[31])) ? (32'd0 - w_uq) : w_uq;
    assign w_rem = (w_div_signed && rs_data[31]) ? (32'd0 - w_ur) : w_ur;

    always_comb begin
        w_calc    = 64'd0;
        w_calc_wr = 1'b1;
        w_is_run  = 1'b0;
        w_is_div  = 1'b0;
        case (mdu_op)
            c_OP_MULT: begin
                w_is_run = 1'b1;
                w_calc   = w_prod_s;
            end
            c_OP_MULTU: begin
                w_is_run = 1'b1;
                w_calc   = w_prod_u;
            end
            c_OP_DIV, c_OP_DIVU: begin
                w_is_run  = 1'b1;
                w_is_div  = 1'b1;
                w_calc    = {w_rem, w_quo};
                w_calc_wr = ~w_divz;
            end
`ifdef MDU_MADD_EN
            c_OP_MADD: begin
                w_is_run = 1'b1;
                w_calc   = {r_hi, r_lo} + w_prod_s;
            end
            c_OP_MADDU: begin
                w_is_run = 1'b1;
                w_calc   = {r_hi, r_lo} + w_prod_u;
            end
            c_OP_MSUB: begin
                w_is_run = 1'b1;
                w_calc   = {r_hi, r_lo} - w_prod_s;
            end
            c_OP_MSUBU: begin
                w_is_run = 1'b1;
                w_calc   = {r_hi, r_lo} - w_prod_u;
            end
`endif
            default: begin
                w_calc = 64'd0;
            end
        endcase
    end

    assign w_cnt_load = w_is_div ? c_DIV_LD : c_MULT_LD;

    // Counter holds the busy cycles remaining; the edge that ends the count==1
    // cycle commits, and done is registered one cycle ahead to land on it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend    <= 64'd0;
            r_pend_wr <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_is_run) begin
                            r_pend    <= w_calc;
                            r_pend_wr <= w_calc_wr;
                            r_cnt     <= w_cnt_load;
                            r_busy    <= 1'b1;
                            r_done    <= (w_cnt_load == 4'd1);
                            r_state   <= S_RUN;
                        end else if (mdu_op == c_OP_MTHI) begin
                            r_hi <= rs_data;
                        end else if (mdu_op == c_OP_MTLO) begin
                            r_lo <= rs_data;
                        end
                    end
                end
                S_RUN: begin
                    if (r_cnt == 4'd1) begin
                        if (r_pend_wr) begin
                            r_hi <= r_pend[63:32];
                            r_lo <= r_pend[31:0];
                        end
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt  <= r_cnt - 4'd1;
                        r_done <= (r_cnt == 4'd2);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rd_data = 32'd0;
        if (mdu_op == c_OP_MFHI) begin
            rd_data = r_hi;
        end else if (mdu_op == c_OP_MFLO) begin
            rd_data = r_lo;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
// ============================================================================
// Module   : tb_mdu_sequencer
// Purpose  : Directed and randomized checks of mdu_sequencer against a
//            behavioural HI/LO model. Define MDU_MADD_EN to cover accumulate ops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_sequencer;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model: architectural HI/LO, busy cycles left, pending result.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_phi = 32'd0;
    logic [31:0] m_plo = 32'd0;
    bit          m_pwr = 1'b0;
    int          m_left = 0;

    mdu_sequencer #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic model_step();
        int          sa;
        int          sb;
        longint      ps;
        logic [63:0] pu;
        logic [63:0] acc;
        if (reset) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_left = 0;
            m_pwr  = 1'b0;
        end else if (m_left > 0) begin
            if (m_left == 1 && m_pwr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
            m_left--;
        end else if (start) begin
            sa  = rs_data;
            sb  = rt_data;
            ps  = longint'(sa) * longint'(sb);
            pu  = {32'd0, rs_data} * {32'd0, rt_data};
            acc = {m_hi, m_lo};
            case (mdu_op)
                OP_MULT: begin
                    {m_phi, m_plo} = ps;
                    m_pwr = 1'b1; m_left = MULT_N;
                end
                OP_MULTU: begin
                    {m_phi, m_plo} = pu;
                    m_pwr = 1'b1; m_left = MULT_N;
                end
                OP_DIV: begin
                    m_left = DIV_N;
                    m_pwr  = (rt_data != 32'd0);
                    if (rs_data == 32'h8000_0000 && rt_data == 32'hFFFF_FFFF) begin
                        m_plo = 32'h8000_0000;
                        m_phi = 32'd0;
                    end else if (m_pwr) begin
                        m_plo = sa / sb;
                        m_phi = sa % sb;
                    end
                end
                OP_DIVU: begin
                    m_left = DIV_N;
                    m_pwr  = (rt_data != 32'd0);
                    if (m_pwr) begin
                        m_plo = rs_data / rt_data;
                        m_phi = rs_data % rt_data;
                    end
                end
                OP_MTHI: m_hi = rs_data;
                OP_MTLO: m_lo = rs_data;
`ifdef MDU_MADD_EN
                OP_MADD: begin
                    {m_phi, m_plo} = acc + $unsigned(ps);
                    m_pwr = 1'b1; m_left = MULT_N;
                end
                OP_MADDU: begin
                    {m_phi, m_plo} = acc + pu;
                    m_pwr = 1'b1; m_left = MULT_N;
                end
                OP_MSUB: begin
                    {m_phi, m_plo} = acc - $unsigned(ps);
                    m_pwr = 1'b1; m_left = MULT_N;
                end
                OP_MSUBU: begin
                    {m_phi, m_plo} = acc - pu;
                    m_pwr = 1'b1; m_left = MULT_N;
                end
`endif
                default: ;
            endcase
        end
    endtask

    // Drive one cycle's inputs, let the edge happen, advance the model.
    task automatic step(input logic s, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic r);
        start   = s;
        mdu_op  = op;
        rs_data = a;
        rt_data = b;
        reset   = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            chk("done", {31'd0, done}, {31'd0, (m_left == 1)});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("rd_data", rd_data,
                (mdu_op == OP_MFHI) ? m_hi : ((mdu_op == OP_MFLO) ? m_lo : 32'd0));
        end
    end

    initial begin
        step(1'b0, OP_NONE, 32'd0, 32'd0, 1'b1);
        step(1'b0, OP_NONE, 32'd0, 32'd0, 1'b1);
        chk_en = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        step(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_busy_first", {31'd0, busy}, 32'd1);
        idle(MULT_N - 1);
        chk("mult_done", {31'd0, done}, 32'd1);
        chk("mult_busy_last", {31'd0, busy}, 32'd1);
        idle(1);
        chk("mult_busy_end", {31'd0, busy}, 32'd0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        step(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
        idle(DIV_N);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        step(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DIV_N);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        step(1'b1, OP_MTHI, 32'h11, 32'd0, 1'b0);
        step(1'b1, OP_MTLO, 32'h22, 32'd0, 1'b0);
        step(1'b1, OP_DIV, 32'd5, 32'd0, 1'b0);
        chk("dz_busy", {31'd0, busy}, 32'd1);
        idle(DIV_N - 1);
        chk("dz_done", {31'd0, done}, 32'd1);
        idle(1);
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);
        step(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DIV_N);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);

        step(1'b1, OP_MTHI, 32'hA5A5_A5A5, 32'd0, 1'b0);
        step(1'b0, OP_MFLO, 32'd0, 32'd0, 1'b0);
        chk("mflo", rd_data, 32'h8000_0000);
        step(1'b0, OP_MFHI, 32'd0, 32'd0, 1'b0);
        chk("mfhi", rd_data, 32'hA5A5_A5A5);
        chk("mthi_nobusy", {31'd0, busy}, 32'd0);
        step(1'b1, OP_MULT, 32'd7, 32'd6, 1'b0);
        step(1'b1, OP_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0);
        idle(MULT_N - 1);
        chk("mtlo_ign_lo", lo, 32'd42);
        chk("mtlo_ign_hi", hi, 32'd0);

        step(1'b1, OP_DIV, 32'd1000, 32'd3, 1'b0);
        idle(2);
        step(1'b0, OP_NONE, 32'd0, 32'd0, 1'b1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        step(1'b1, OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0);
        idle(MULT_N);
        chk("post_abort_hi", hi, 32'd1);
        chk("post_abort_lo", lo, 32'd0);

        step(1'b1, 4'd13, 32'h1234, 32'h5678, 1'b0);
        chk("undef_busy", {31'd0, busy}, 32'd0);

`ifdef MDU_MADD_EN
        step(1'b1, OP_MTHI, 32'd0, 32'd0, 1'b0);
        step(1'b1, OP_MTLO, 32'd5, 32'd0, 1'b0);
        step(1'b1, OP_MADD, 32'd2, 32'd3, 1'b0);
        idle(MULT_N);
        chk("madd_lo", lo, 32'd11);
        chk("madd_hi", hi, 32'd0);
        step(1'b1, OP_MSUBU, 32'd1, 32'd12, 1'b0);
        idle(MULT_N);
        chk("msubu_hi", hi, 32'hFFFF_FFFF);
        chk("msubu_lo", lo, 32'hFFFF_FFFF);
`else
        step(1'b1, OP_MADD, 32'd2, 32'd3, 1'b0);
        chk("madd_off_busy", {31'd0, busy}, 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 rnd_opnd(), rnd_opnd(), ($urandom_range(0, 399) == 0));
        end
        idle(DIV_N + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
